// File: rtl/philv_mem_arbiter_pkg.sv
// Shared arbiter definitions: default widths, FSM state encodings, requester select.
// No logic; imported by the arbiter top and its priority sub-block.
// Encodings are shared with the core controller and testbenches, so keep them stable.
package philv_mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_WAIT_I = 2'd1;
  localparam logic [1:0] ARB_WAIT_D = 2'd2;

  typedef enum logic {
    SEL_I = 1'b0,
    SEL_D = 1'b1
  } sel_t;

endpackage

// File: rtl/philv_arb_priority.sv
// Data-first requester select with a fetch starvation guard.
// Latency: sel is combinational; starve_cnt updates on the clock edge.
// Backpressure: the counter only moves on actual grants, so stalled memory does not age it.
module philv_arb_priority
  import philv_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rstb,
  input  logic idle,
  input  logic if_req,
  input  logic dm_req,
  input  logic if_gnt,
  input  logic dm_gnt,
  output sel_t sel
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             at_limit;

  assign at_limit = (starve_cnt >= LIMIT);

  always_comb begin
    sel = SEL_I;
    if (dm_req && !(if_req && at_limit)) sel = SEL_D;
  end

  // Fetch going away while idle means nobody is starving any more.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      starve_cnt <= '0;
    end else if (if_gnt || (idle && !if_req)) begin
      starve_cnt <= '0;
    end else if (dm_gnt && if_req && !at_limit) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/philv_mem_arbiter.sv
// Shares one single-port memory between fetch (IF) and load/store (MEM), one transaction in flight.
// Latency: request muxed to memory in the same cycle; response forwarded combinationally on mem_rvalid.
// Backpressure: without mem_gnt the arbiter stays idle and re-arbitrates every cycle.
module philv_mem_arbiter
  import philv_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                spurious
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       idle;
  sel_t       sel;

  assign idle = (state == ARB_IDLE);

  philv_arb_priority #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_priority (
    .clk    (clk),
    .rstb   (rstb),
    .idle   (idle),
    .if_req (if_req),
    .dm_req (dm_req),
    .if_gnt (if_gnt),
    .dm_gnt (dm_gnt),
    .sel    (sel)
  );

  // Every output is qualified by rstb so a held request cannot leak out during reset.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    if (rstb && idle) begin
      if (sel == SEL_D && dm_req) begin
        mem_req   = 1'b1;
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
        mem_be    = dm_be;
        dm_gnt    = mem_gnt;
      end else if (sel == SEL_I && if_req) begin
        mem_req   = 1'b1;
        mem_addr  = if_addr;
        mem_be    = '1;
        if_gnt    = mem_gnt;
      end
    end
  end

  always_comb begin
    if_rvalid = rstb && (state == ARB_WAIT_I) && mem_rvalid;
    dm_rvalid = rstb && (state == ARB_WAIT_D) && mem_rvalid;
    if_rdata  = if_rvalid ? mem_rdata : '0;
    dm_rdata  = dm_rvalid ? mem_rdata : '0;
    spurious  = rstb && idle && mem_rvalid;
  end

  // A grant coinciding with rvalid in a wait state is ignored: mem_req is low there.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (dm_gnt)      state_nxt = ARB_WAIT_D;
        else if (if_gnt) state_nxt = ARB_WAIT_I;
      end
      ARB_WAIT_I,
      ARB_WAIT_D: begin
        if (mem_rvalid) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

endmodule

// File: tb/tb_philv_mem_arbiter.sv
// Directed bench for philv_mem_arbiter: scoreboard of expected responses pushed on grant,
// popped and compared on rvalid, plus per-step checks of grants, muxed fields and error flags.
module tb_philv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rstb;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        spurious;

  always #5 clk = ~clk;

  philv_mem_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .STARVE_LIMIT (4)
  ) dut (
    .clk        (clk),
    .rstb       (rstb),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_be      (dm_be),
    .dm_gnt     (dm_gnt),
    .dm_rvalid  (dm_rvalid),
    .dm_rdata   (dm_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .spurious   (spurious)
  );

  typedef struct packed {
    logic        d;
    logic        chk_data;
    logic [31:0] dat;
  } exp_t;

  exp_t        sb[$];
  int          ntests = 0;
  int          nfail  = 0;
  logic        auto_mem;
  int          lat;
  logic        pend;
  int          pcnt;
  logic [31:0] pdat;
  logic [5:0]  pat;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h10) ? 32'h0050_0093 : ((a ^ 32'hC0DE_0000) + 32'h1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observe one cycle away from the clock edge; feed the scoreboard from grants and responses.
  task automatic sample();
    exp_t e;
    @(negedge clk);
    if (if_gnt || dm_gnt) begin
      chk("gnt_exclusive", {63'd0, if_gnt & dm_gnt}, 64'd0);
      e.d        = dm_gnt;
      e.chk_data = !(dm_gnt && dm_we);
      e.dat      = mem_fn(dm_gnt ? dm_addr : if_addr);
      sb.push_back(e);
      if (auto_mem) begin
        pend = 1'b1;
        pcnt = lat;
        pdat = e.dat;
      end
    end
    if (if_rvalid || dm_rvalid) begin
      chk("rvalid_exclusive", {63'd0, if_rvalid & dm_rvalid}, 64'd0);
      chk("sb_has_entry", {63'd0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_owner", {63'd0, dm_rvalid}, {63'd0, e.d});
        if (e.chk_data) chk("rsp_data", {32'd0, dm_rvalid ? dm_rdata : if_rdata}, {32'd0, e.dat});
      end
    end
  endtask

  // Step past the rising edge; the memory model answers `lat` cycles after a grant.
  task automatic adv();
    @(posedge clk);
    #1;
    if (auto_mem) begin
      mem_rvalid = 1'b0;
      if (pend) begin
        pcnt--;
        if (pcnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = pdat;
          pend       = 1'b0;
        end
      end
    end
  endtask

  task automatic idle_cycle();
    sample();
    adv();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstb = 1'b0; if_req = 1'b1; if_addr = 32'h10;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40; dm_wdata = 32'h1234_5678; dm_be = 4'hF;
    mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    auto_mem = 1'b1; lat = 1; pend = 1'b0; pcnt = 0; pdat = 32'h0;

    // 1: reset holds every output low even with both requests asserted
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("rst_outputs_zero",
          {63'd0, |{if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, mem_req, mem_we,
                    mem_addr, mem_wdata, mem_be, spurious}}, 64'd0);
      adv();
    end
    rstb = 1'b1;
    sample();
    chk("rst_first_dgnt", {63'd0, dm_gnt}, 64'd1);
    chk("rst_first_ignt", {63'd0, if_gnt}, 64'd0);
    adv();
    if_req = 1'b0; dm_req = 1'b0;
    sample();
    chk("rst_first_drvalid", {63'd0, dm_rvalid}, 64'd1);
    adv();
    idle_cycle();

    // 2: lone fetch, response three cycles after the grant
    if_req = 1'b1; if_addr = 32'h10; lat = 3;
    sample();
    chk("fetch_ignt_c0", {63'd0, if_gnt}, 64'd1);
    chk("fetch_addr_c0", {32'd0, mem_addr}, 64'h10);
    adv();
    if_req = 1'b0;
    for (int c = 1; c < 3; c++) begin
      sample();
      chk("fetch_no_rvalid_early", {62'd0, if_rvalid, dm_rvalid}, 64'd0);
      adv();
    end
    sample();
    chk("fetch_rvalid_c3", {63'd0, if_rvalid}, 64'd1);
    chk("fetch_rdata_c3", {32'd0, if_rdata}, 64'h0050_0093);
    chk("fetch_no_drvalid", {63'd0, dm_rvalid}, 64'd0);
    adv();
    idle_cycle();

    // 3: sustained tie -> four data grants, one fetch, then data again
    if_addr = 32'h100; dm_addr = 32'h300; dm_we = 1'b0;
    if_req = 1'b1; dm_req = 1'b1; lat = 1;
    pat = 6'b10_1111;
    for (int i = 0; i < 6; i++) begin
      sample();
      chk($sformatf("tie_dgnt_%0d", i), {63'd0, dm_gnt}, {63'd0, pat[i]});
      chk($sformatf("tie_ignt_%0d", i), {63'd0, if_gnt}, {63'd0, ~pat[i]});
      adv();
      if (i == 5) begin
        if_req = 1'b0; dm_req = 1'b0;
      end
      sample();
      chk("tie_wait_no_memreq", {63'd0, mem_req}, 64'd0);
      adv();
    end
    idle_cycle();

    // 4: store fields pass through exactly; fetch waits until after the ack
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'b0011;
    if_req = 1'b1; if_addr = 32'h20; lat = 2;
    sample();
    chk("st_dgnt", {63'd0, dm_gnt}, 64'd1);
    chk("st_fields", {26'd0, mem_req, mem_we, mem_addr, mem_be}, {26'd0, 1'b1, 1'b1, 32'h200, 4'b0011});
    chk("st_wdata", {32'd0, mem_wdata}, 64'hDEAD_BEEF);
    chk("st_ignt_c0", {63'd0, if_gnt}, 64'd0);
    adv();
    dm_req = 1'b0; dm_we = 1'b0; dm_wdata = 32'h0; dm_be = 4'h0;
    sample();
    chk("st_ignt_wait", {63'd0, if_gnt}, 64'd0);
    adv();
    sample();
    chk("st_ack", {63'd0, dm_rvalid}, 64'd1);
    chk("st_ignt_ack", {63'd0, if_gnt}, 64'd0);
    adv();
    sample();
    chk("st_ignt_after", {63'd0, if_gnt}, 64'd1);
    chk("st_fetch_fields", {27'd0, mem_we, mem_addr, mem_be}, {27'd0, 1'b0, 32'h20, 4'hF});
    adv();
    if_req = 1'b0;
    repeat (3) idle_cycle();

    // 5: memory backpressure; data drops out in cycle 3 and fetch address takes over
    mem_gnt = 1'b0; dm_req = 1'b1; dm_addr = 32'h300; if_req = 1'b1; if_addr = 32'h44; lat = 1;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) dm_req = 1'b0;
      sample();
      chk("bp_no_gnt", {62'd0, if_gnt, dm_gnt}, 64'd0);
      chk("bp_memreq", {63'd0, mem_req}, 64'd1);
      if (i < 3) chk("bp_addr_d", {32'd0, mem_addr}, 64'h300);
      else       chk("bp_addr_i", {28'd0, mem_be, mem_addr}, {28'd0, 4'hF, 32'h44});
      adv();
    end
    mem_gnt = 1'b1;
    sample();
    chk("bp_release_ignt", {63'd0, if_gnt}, 64'd1);
    adv();
    if_req = 1'b0;
    repeat (3) idle_cycle();

    // 6: stray response in idle, then reset in the middle of a load
    auto_mem = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_0001;
    sample();
    chk("spur_idle", {61'd0, spurious, if_rvalid, dm_rvalid}, 64'd4);
    adv();
    mem_rvalid = 1'b0;
    sample();
    chk("spur_clears", {63'd0, spurious}, 64'd0);
    adv();
    dm_req = 1'b1; dm_addr = 32'h80;
    sample();
    chk("rstmid_dgnt", {63'd0, dm_gnt}, 64'd1);
    adv();
    dm_req = 1'b0; rstb = 1'b0;
    sample();
    chk("rstmid_outs", {61'd0, mem_req, dm_rvalid, spurious}, 64'd0);
    adv();
    rstb = 1'b1;
    sb.delete();
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_0002;
    sample();
    chk("rstmid_late_spur", {62'd0, spurious, dm_rvalid}, 64'd2);
    adv();
    mem_rvalid = 1'b0;
    idle_cycle();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
